// File: rtl/pipe_hold_sched.sv
// Pipeline hold/flush scheduler for the core front end.
// Merges stall requests, sequences jump flushes, defers interrupts, watches stall length.
module pipe_hold_sched #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MAX_STALL    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_ex_i,
    input  logic        hold_clint_i,
    input  logic        hold_rib_i,
    input  logic [7:0]  int_flag_i,
    input  logic [7:0]  int_ack_i,
    input  logic        clr_timeout_i,
    output logic [2:0]  hold_flag_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic [7:0]  int_flag_o,
    output logic        stall_timeout_o
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PEND  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [2:0]  LP_NONE   = 3'd0;
    localparam logic [2:0]  LP_PC     = 3'd1;
    localparam logic [2:0]  LP_ID     = 3'd3;
    localparam logic [3:0]  LP_FLUSH  = 4'(FLUSH_CYCLES);
    localparam logic [15:0] LP_MS1    = 16'(MAX_STALL - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_fcnt;
    logic [3:0]  w_fcnt_nxt;
    logic [31:0] r_paddr;
    logic [31:0] w_paddr_nxt;
    logic        w_issue;
    logic [31:0] w_issue_addr;
    logic [2:0]  w_req;
    logic [2:0]  w_forced;
    logic [2:0]  w_hold_nxt;
    logic [7:0]  r_pend;
    logic [7:0]  w_pend_nxt;
    logic [7:0]  w_int_nxt;
    logic [15:0] r_scnt;
    logic [15:0] w_scnt_nxt;
    logic        w_to_set;
    logic        w_to_nxt;

    // Jump sequencing: issue, defer under bus hold, or count down the flush.
    always_comb begin
        w_state_nxt  = r_state;
        w_fcnt_nxt   = r_fcnt;
        w_paddr_nxt  = r_paddr;
        w_issue      = 1'b0;
        w_issue_addr = jump_addr_i;
        unique case (r_state)
            RUN: begin
                if (jump_flag_i) begin
                    if (hold_rib_i) begin
                        w_paddr_nxt = jump_addr_i;
                        w_state_nxt = PEND;
                        w_fcnt_nxt  = 4'd0;
                    end else begin
                        w_issue     = 1'b1;
                        w_state_nxt = FLUSH;
                        w_fcnt_nxt  = LP_FLUSH;
                    end
                end
            end
            PEND: begin
                if (jump_flag_i) begin
                    w_paddr_nxt = jump_addr_i;
                end
                if (!hold_rib_i) begin
                    w_issue      = 1'b1;
                    w_issue_addr = jump_flag_i ? jump_addr_i : r_paddr;
                    w_state_nxt  = FLUSH;
                    w_fcnt_nxt   = LP_FLUSH;
                end
            end
            FLUSH: begin
                if (jump_flag_i) begin
                    if (hold_rib_i) begin
                        w_paddr_nxt = jump_addr_i;
                        w_state_nxt = PEND;
                        w_fcnt_nxt  = 4'd0;
                    end else begin
                        w_issue     = 1'b1;
                        w_fcnt_nxt  = LP_FLUSH;
                    end
                end else begin
                    w_fcnt_nxt = r_fcnt - 4'd1;
                    if (r_fcnt <= 4'd1) begin
                        w_fcnt_nxt  = 4'd0;
                        w_state_nxt = RUN;
                    end
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_fcnt_nxt  = 4'd0;
            end
        endcase
    end

    // Next hold level: strongest of the stall requests and the FSM-forced level.
    always_comb begin
        w_req = LP_NONE;
        if (hold_ex_i || hold_clint_i) begin
            w_req = LP_ID;
        end else if (hold_rib_i) begin
            w_req = LP_PC;
        end
        w_forced = LP_NONE;
        if (w_state_nxt == PEND) begin
            w_forced = LP_PC;
        end else if (w_state_nxt == FLUSH && w_fcnt_nxt != 4'd0) begin
            w_forced = LP_ID;
        end
        w_hold_nxt = (w_req > w_forced) ? w_req : w_forced;
    end

    // Interrupt pending bits survive holds; presented only in a running, unheld cycle.
    always_comb begin
        w_pend_nxt = (r_pend & ~int_ack_i) | int_flag_i;
        w_int_nxt  = 8'd0;
        if (w_hold_nxt == LP_NONE && w_state_nxt == RUN) begin
            w_int_nxt = w_pend_nxt;
        end
    end

    // Stall length supervision; a set condition beats a same-cycle clear.
    always_comb begin
        w_scnt_nxt = 16'd0;
        if (hold_flag_o != LP_NONE) begin
            w_scnt_nxt = (r_scnt == 16'hFFFF) ? r_scnt : r_scnt + 16'd1;
        end
        w_to_set = (w_hold_nxt != LP_NONE) && (w_scnt_nxt == LP_MS1);
        w_to_nxt = stall_timeout_o;
        if (w_to_set) begin
            w_to_nxt = 1'b1;
        end else if (clr_timeout_i) begin
            w_to_nxt = 1'b0;
        end
    end

    // All state and outputs registered; reset discards everything in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= RUN;
            r_fcnt          <= 4'd0;
            r_paddr         <= 32'd0;
            r_pend          <= 8'd0;
            r_scnt          <= 16'd0;
            hold_flag_o     <= LP_NONE;
            jump_flag_o     <= 1'b0;
            jump_addr_o     <= 32'd0;
            int_flag_o      <= 8'd0;
            stall_timeout_o <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_fcnt          <= w_fcnt_nxt;
            r_paddr         <= w_paddr_nxt;
            r_pend          <= w_pend_nxt;
            r_scnt          <= w_scnt_nxt;
            hold_flag_o     <= w_hold_nxt;
            jump_flag_o     <= w_issue;
            if (w_issue) begin
                jump_addr_o <= w_issue_addr;
            end
            int_flag_o      <= w_int_nxt;
            stall_timeout_o <= w_to_nxt;
        end
    end

endmodule
